// File: rtl/mda_vram_arbiter.sv
// mda_vram_arbiter: shares one single-port video RAM between the MDA display fetch and a host port
// Ports: clk/rst (async, active-high); blank gates host grants when HOST_IN_ACTIVE=0;
// disp_* display read port (req/addr in, ack/rdata out); host_* read/write port;
// mem_* single-port RAM interface (1-cycle read latency); stall_clr/stall_cnt host starvation counter;
// busy high while an access is in flight.
module mda_vram_arbiter #(
  parameter int AW = 12,
  parameter int DW = 8,
  parameter int HOST_IN_ACTIVE = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          blank,
  input  logic          disp_req,
  input  logic [AW-1:0] disp_addr,
  output logic          disp_ack,
  output logic [DW-1:0] disp_rdata,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_ack,
  output logic [DW-1:0] host_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          stall_clr,
  output logic [15:0]   stall_cnt,
  output logic          busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;
  state_t state, state_nx;
  logic own_host, we_q, grant_disp, grant_host, host_wait;
  always_comb begin
    grant_disp = (state == IDLE) && disp_req;
    grant_host = (state == IDLE) && !disp_req && host_req && ((HOST_IN_ACTIVE != 0) || blank);
    // host waits whenever it asks but is not the owner of the access being served
    host_wait = host_req && !(grant_host || ((state != IDLE) && own_host));
    state_nx = state;
    state_nx = (state == IDLE) ? ((grant_disp || grant_host) ? ISSUE : IDLE) :
               (state == ISSUE) ? WAIT : (state == WAIT) ? ACK : IDLE;
  end
  // mem_addr/mem_we/mem_wdata double as the latched request, so later input changes are ignored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      own_host   <= 1'b0;
      we_q       <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      disp_ack   <= 1'b0;
      host_ack   <= 1'b0;
      disp_rdata <= '0;
      host_rdata <= '0;
      stall_cnt  <= '0;
    end else begin
      state    <= state_nx;
      busy     <= state_nx != IDLE;
      mem_en   <= grant_disp || grant_host;
      mem_we   <= grant_host && host_we;
      disp_ack <= (state == WAIT) && !own_host;
      host_ack <= (state == WAIT) && own_host;
      if (grant_disp || grant_host) begin
        own_host <= grant_host;
        we_q     <= grant_host && host_we;
        mem_addr <= grant_host ? host_addr : disp_addr;
      end
      if (grant_host && host_we) mem_wdata <= host_wdata;
      if ((state == WAIT) && !we_q && own_host) host_rdata <= mem_rdata;
      if ((state == WAIT) && !own_host) disp_rdata <= mem_rdata;
      stall_cnt <= stall_clr ? 16'h0 : (host_wait && (stall_cnt != 16'hFFFF)) ? stall_cnt + 16'h1 : stall_cnt;
    end
  end
endmodule

// File: tb/tb_mda_vram_arbiter.sv
// tb_mda_vram_arbiter: directed checks of the arbiter with host allowed always (a) and only in blank (b)
module tb_mda_vram_arbiter;
  logic clk = 0, rst = 1, blank = 1, disp_req = 0, host_req = 0, host_we = 0, stall_clr = 0;
  logic [11:0] disp_addr = 0, host_addr = 0;
  logic [7:0] host_wdata = 0;
  logic a_disp_ack, a_host_ack, a_mem_en, a_mem_we, a_busy;
  logic b_disp_ack, b_host_ack, b_mem_en, b_mem_we, b_busy;
  logic [7:0] a_disp_rdata, a_host_rdata, a_mem_wdata, a_mem_rdata;
  logic [7:0] b_disp_rdata, b_host_rdata, b_mem_wdata, b_mem_rdata;
  logic [11:0] a_mem_addr, b_mem_addr;
  logic [15:0] a_stall_cnt, b_stall_cnt;
  logic [7:0] ma [0:4095];
  logic [7:0] mb [0:4095];
  int checks = 0, failures = 0;
  logic seen_en;
  always #5 clk = ~clk;
  mda_vram_arbiter #(.AW(12), .DW(8), .HOST_IN_ACTIVE(1)) dut_a (
    .clk(clk), .rst(rst), .blank(blank), .disp_req(disp_req), .disp_addr(disp_addr),
    .disp_ack(a_disp_ack), .disp_rdata(a_disp_rdata), .host_req(host_req), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_ack(a_host_ack), .host_rdata(a_host_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata), .stall_clr(stall_clr), .stall_cnt(a_stall_cnt), .busy(a_busy));
  mda_vram_arbiter #(.AW(12), .DW(8), .HOST_IN_ACTIVE(0)) dut_b (
    .clk(clk), .rst(rst), .blank(blank), .disp_req(disp_req), .disp_addr(disp_addr),
    .disp_ack(b_disp_ack), .disp_rdata(b_disp_rdata), .host_req(host_req), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_ack(b_host_ack), .host_rdata(b_host_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .stall_clr(stall_clr), .stall_cnt(b_stall_cnt), .busy(b_busy));
  always @(posedge clk) begin
    if (a_mem_en) begin
      if (a_mem_we) ma[a_mem_addr] <= a_mem_wdata;
      a_mem_rdata <= ma[a_mem_addr];
    end
    if (b_mem_en) begin
      if (b_mem_we) mb[b_mem_addr] <= b_mem_wdata;
      b_mem_rdata <= mb[b_mem_addr];
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic reset_pulse();
    rst = 1;
    step();
    rst = 0;
  endtask
  initial begin
    for (int i = 0; i < 4096; i++) begin
      ma[i] = 8'h00;
      mb[i] = 8'h00;
    end
    ma[12'h010] = 8'h41;
    mb[12'h010] = 8'h41;
    ma[12'h000] = 8'h5A;
    a_mem_rdata = 0;
    b_mem_rdata = 0;
    step();
    step();
    chk("rst_mem_en", a_mem_en, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_stall", a_stall_cnt, 0);
    chk("rst_acks", {a_disp_ack, a_host_ack}, 0);
    chk("rst_addr", a_mem_addr, 0);
    rst = 0;
    // 1: display read
    disp_req = 1;
    disp_addr = 12'h010;
    step();
    chk("t1_en", a_mem_en, 1);
    chk("t1_we", a_mem_we, 0);
    chk("t1_addr", a_mem_addr, 12'h010);
    chk("t1_busy1", a_busy, 1);
    step();
    chk("t1_en_wait", a_mem_en, 0);
    chk("t1_busy2", a_busy, 1);
    chk("t1_ack_early", a_disp_ack, 0);
    step();
    chk("t1_ack", a_disp_ack, 1);
    chk("t1_rdata", a_disp_rdata, 8'h41);
    chk("t1_busy3", a_busy, 1);
    disp_req = 0;
    step();
    chk("t1_ack_pulse", a_disp_ack, 0);
    chk("t1_busy4", a_busy, 0);
    // 2: host write then display readback
    host_req = 1;
    host_we = 1;
    host_addr = 12'h7CF;
    host_wdata = 8'h70;
    step();
    chk("t2_en", a_mem_en, 1);
    chk("t2_we", a_mem_we, 1);
    chk("t2_addr", a_mem_addr, 12'h7CF);
    chk("t2_wdata", a_mem_wdata, 8'h70);
    step();
    step();
    chk("t2_ack", a_host_ack, 1);
    chk("t2_rdata_hold", a_host_rdata, 0);
    host_req = 0;
    host_we = 0;
    step();
    disp_req = 1;
    disp_addr = 12'h7CF;
    step();
    step();
    step();
    chk("t2_readback_ack", a_disp_ack, 1);
    chk("t2_readback", a_disp_rdata, 8'h70);
    disp_req = 0;
    step();
    stall_clr = 1;
    step();
    stall_clr = 0;
    // 3: simultaneous requests, display wins
    disp_req = 1;
    disp_addr = 12'h010;
    host_req = 1;
    host_addr = 12'h7CF;
    step();
    chk("t3_disp_first", a_mem_addr, 12'h010);
    step();
    step();
    chk("t3_disp_ack", a_disp_ack, 1);
    chk("t3_host_not_yet", a_host_ack, 0);
    disp_req = 0;
    step();
    chk("t3_stall", a_stall_cnt, 4);
    chk("t3_idle", a_busy, 0);
    step();
    chk("t3_host_en", a_mem_en, 1);
    chk("t3_host_addr", a_mem_addr, 12'h7CF);
    step();
    step();
    chk("t3_host_ack", a_host_ack, 1);
    chk("t3_host_rdata", a_host_rdata, 8'h70);
    chk("t3_stall_hold", a_stall_cnt, 4);
    host_req = 0;
    step();
    // 4: host blocked during active video when HOST_IN_ACTIVE=0
    reset_pulse();
    blank = 0;
    host_req = 1;
    host_addr = 12'h010;
    seen_en = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      seen_en = seen_en | b_mem_en;
    end
    chk("t4_no_en", seen_en, 0);
    chk("t4_stall", b_stall_cnt, 10);
    blank = 1;
    step();
    chk("t4_grant", b_mem_en, 1);
    chk("t4_stall_hold", b_stall_cnt, 10);
    step();
    step();
    chk("t4_ack", b_host_ack, 1);
    chk("t4_rdata", b_host_rdata, 8'h41);
    host_req = 0;
    step();
    // 5: saturation and clear
    reset_pulse();
    blank = 0;
    host_req = 1;
    for (int i = 0; i < 65540; i++) step();
    chk("t5_sat", b_stall_cnt, 16'hFFFF);
    stall_clr = 1;
    step();
    chk("t5_clr", b_stall_cnt, 0);
    stall_clr = 0;
    step();
    chk("t5_recount", b_stall_cnt, 1);
    host_req = 0;
    blank = 1;
    // 6: async reset during WAIT abandons the access
    reset_pulse();
    disp_req = 1;
    disp_addr = 12'h010;
    step();
    step();
    chk("t6_in_wait", a_busy, 1);
    rst = 1;
    #1;
    chk("t6_async_busy", a_busy, 0);
    chk("t6_async_addr", a_mem_addr, 0);
    chk("t6_async_rdata", a_disp_rdata, 0);
    step();
    chk("t6_no_ack", a_disp_ack, 0);
    disp_addr = 12'h000;
    rst = 0;
    step();
    chk("t6_en", a_mem_en, 1);
    step();
    step();
    chk("t6_ack", a_disp_ack, 1);
    chk("t6_rdata", a_disp_rdata, 8'h5A);
    disp_req = 0;
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
